// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard controller for the 5-stage LEGv8 pipeline. It looks at the
//   IF/ID, ID/EX, EX/MEM and MEM/WB register outputs and drives their load
//   enables, bubbles and flushes. It also picks the EX operand forwarding
//   sources and keeps saturating stall and flush counters.
//
//   Hazards resolved, highest priority first:
//     taken-branch flush  >  multiply occupancy of EX  >  load-use stall
//
// Ports
//   clk, reset (sync, active-low)
//   id_*_i        source registers and use flags of the instruction in ID
//   ex_*_i        source/dest registers and control of the instruction in EX
//   mem_*_i       EX/MEM RegWrite and Rw; branch-taken from MEM
//   wb_*_i        MEM/WB RegWrite and Rw
//   *_write_o     PC, IF/ID and ID/EX load enables
//   *_bubble_o    zero the control fields entering ID/EX or EX/MEM
//   flush_*_o     clear a pipeline register on the next edge
//   fwd_a/b_o     00 regfile, 10 EX/MEM, 01 MEM/WB
//   busy_state_o  00 RUN, 01 MUL
//   stall_cnt_o   cycles with pc_write_o=0 (saturating)
//   flush_cnt_o   taken-branch flushes (saturating)
module pipe_hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn_i,
    input  logic [4:0]       id_rm_i,
    input  logic             id_use_rn_i,
    input  logic             id_use_rm_i,
    input  logic [4:0]       ex_rn_i,
    input  logic [4:0]       ex_rm_i,
    input  logic             ex_memread_i,
    input  logic             ex_mult_i,
    input  logic [4:0]       ex_rw_i,
    input  logic             mem_regwrite_i,
    input  logic [4:0]       mem_rw_i,
    input  logic             wb_regwrite_i,
    input  logic [4:0]       wb_rw_i,
    input  logic             mem_br_taken_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_write_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_bubble_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             flush_ex_mem_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [1:0]       busy_state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int MW = $clog2(MULT_LAT) + 1;
    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [1:0] {RUN = 2'b00, MUL = 2'b01} state_t;

    state_t          state_q;
    logic [MW-1:0]   mul_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic load_use, mul_busy;

    // X31 reads as zero and is never written, so it never produces a hazard.
    assign load_use = ex_memread_i && (ex_rw_i != XZR) &&
                      ((id_use_rn_i && (id_rn_i == ex_rw_i)) ||
                       (id_use_rm_i && (id_rm_i == ex_rw_i)));

    // A multiply occupies EX from the cycle it is first seen in RUN.
    assign mul_busy = (state_q == MUL) || ex_mult_i;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic mwe, input logic [4:0] mrw,
                                           input logic wwe, input logic [4:0] wrw);
        if (mwe && mrw != XZR && mrw == src)      return 2'b10;
        else if (wwe && wrw != XZR && wrw == src) return 2'b01;
        else                                      return 2'b00;
    endfunction

    always_comb begin
        pc_write_o      = 1'b0;
        if_id_write_o   = 1'b0;
        id_ex_write_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_mem_bubble_o = 1'b0;
        flush_if_id_o   = 1'b0;
        flush_id_ex_o   = 1'b0;
        flush_ex_mem_o  = 1'b0;
        fwd_a_o         = 2'b00;
        fwd_b_o         = 2'b00;
        if (reset) begin
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
            id_ex_write_o = 1'b1;
            fwd_a_o = fwd_sel(ex_rn_i, mem_regwrite_i, mem_rw_i, wb_regwrite_i, wb_rw_i);
            fwd_b_o = fwd_sel(ex_rm_i, mem_regwrite_i, mem_rw_i, wb_regwrite_i, wb_rw_i);
            if (mem_br_taken_i) begin
                flush_if_id_o  = 1'b1;
                flush_id_ex_o  = 1'b1;
                flush_ex_mem_o = 1'b1;
            end else if (mul_busy) begin
                pc_write_o      = 1'b0;
                if_id_write_o   = 1'b0;
                id_ex_write_o   = 1'b0;
                ex_mem_bubble_o = 1'b1;
            end else if (load_use) begin
                // The load moves on to MEM, so one bubble clears the hazard.
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            mul_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (mem_br_taken_i) begin
                // Anything in EX is younger than the branch, so abort it.
                state_q   <= RUN;
                mul_cnt_q <= '0;
                if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
            end else if (state_q == RUN) begin
                if (ex_mult_i) begin
                    state_q   <= MUL;
                    mul_cnt_q <= MW'(MULT_LAT - 1);
                end
            end else begin
                mul_cnt_q <= mul_cnt_q - 1'b1;
                if (mul_cnt_q == MW'(1)) state_q <= RUN;
            end
            if (!pc_write_o && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign busy_state_o = state_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rn, id_rm, ex_rn, ex_rm, ex_rw, mem_rw, wb_rw;
    logic       id_use_rn, id_use_rm, ex_memread, ex_mult;
    logic       mem_regwrite, wb_regwrite, mem_br_taken;

    logic        pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]  fwd_a, fwd_b, busy_state;
    logic [15:0] stall_cnt, flush_cnt;

    // Narrow-counter copy driven by the same stimulus, used for saturation.
    logic        s_pc, s_ifid, s_idex, s_idb, s_exb, s_f0, s_f1, s_f2;
    logic [1:0]  s_fa, s_fb, s_bs, s_sc, s_fc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MULT_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rn_i(id_rn), .id_rm_i(id_rm), .id_use_rn_i(id_use_rn), .id_use_rm_i(id_use_rm),
        .ex_rn_i(ex_rn), .ex_rm_i(ex_rm), .ex_memread_i(ex_memread), .ex_mult_i(ex_mult),
        .ex_rw_i(ex_rw), .mem_regwrite_i(mem_regwrite), .mem_rw_i(mem_rw),
        .wb_regwrite_i(wb_regwrite), .wb_rw_i(wb_rw), .mem_br_taken_i(mem_br_taken),
        .pc_write_o(pc_write), .if_id_write_o(if_id_write), .id_ex_write_o(id_ex_write),
        .id_ex_bubble_o(id_ex_bubble), .ex_mem_bubble_o(ex_mem_bubble),
        .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex), .flush_ex_mem_o(flush_ex_mem),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .busy_state_o(busy_state),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipe_hazard_ctrl #(.MULT_LAT(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .id_rn_i(id_rn), .id_rm_i(id_rm), .id_use_rn_i(id_use_rn), .id_use_rm_i(id_use_rm),
        .ex_rn_i(ex_rn), .ex_rm_i(ex_rm), .ex_memread_i(ex_memread), .ex_mult_i(ex_mult),
        .ex_rw_i(ex_rw), .mem_regwrite_i(mem_regwrite), .mem_rw_i(mem_rw),
        .wb_regwrite_i(wb_regwrite), .wb_rw_i(wb_rw), .mem_br_taken_i(mem_br_taken),
        .pc_write_o(s_pc), .if_id_write_o(s_ifid), .id_ex_write_o(s_idex),
        .id_ex_bubble_o(s_idb), .ex_mem_bubble_o(s_exb),
        .flush_if_id_o(s_f0), .flush_id_ex_o(s_f1), .flush_ex_mem_o(s_f2),
        .fwd_a_o(s_fa), .fwd_b_o(s_fb), .busy_state_o(s_bs),
        .stall_cnt_o(s_sc), .flush_cnt_o(s_fc)
    );

    // {pc,ifid,idex,id_ex_bubble,ex_mem_bubble}{flush if/id,id/ex,ex/mem}{fa}{fb}{busy}{stall}{flush}
    typedef struct {
        string       tag;
        logic [45:0] v;
    } exp_t;

    exp_t sb[$];

    localparam logic [4:0] EN  = 5'b11100;  // run, no hazard
    localparam logic [4:0] MS  = 5'b00001;  // multiply stall
    localparam logic [4:0] LU  = 5'b00110;  // load-use stall

    logic [45:0] obs;
    assign obs = {pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble,
                  flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b, busy_state,
                  stall_cnt, flush_cnt};

    // Push the expectation for the current cycle, check it mid-cycle, then
    // advance to just after the next active edge.
    task automatic step(input string tag, input logic [4:0] en, input logic [2:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] bs,
                        input int sc, input int fc);
        exp_t e, p;
        e.tag = tag;
        e.v   = {en, fl, fa, fb, bs, sc[15:0], fc[15:0]};
        sb.push_back(e);
        @(negedge clk);
        p = sb.pop_front();
        total++;
        assert (obs === p.v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", p.tag, obs, p.v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {id_rn, id_rm, ex_rn, ex_rm, ex_rw, mem_rw, wb_rw} = '0;
        {id_use_rn, id_use_rm, ex_memread, mem_regwrite, wb_regwrite, mem_br_taken} = '0;
        ex_mult = 1'b1;
        @(posedge clk); #1;

        // reset held with a multiply requested
        step("rst0", 5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
        step("rst1", 5'b00000, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
        reset = 1'b1; ex_mult = 1'b0;
        step("rst_rel", EN, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);

        // load-use on rn
        ex_memread = 1'b1; ex_rw = 5'd3; id_rn = 5'd3; id_use_rn = 1'b1;
        step("lu_rn", LU, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);
        ex_memread = 1'b0;
        step("lu_rn_after", EN, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0);

        // XZR never matches: load-use and forwarding
        ex_memread = 1'b1; ex_rw = 5'd31; id_rn = 5'd31;
        mem_regwrite = 1'b1; mem_rw = 5'd31; wb_regwrite = 1'b1; wb_rw = 5'd31; ex_rn = 5'd31;
        step("xzr", EN, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0);
        {ex_memread, mem_regwrite, wb_regwrite, id_use_rn} = '0;
        {id_rn, ex_rw, mem_rw, wb_rw, ex_rn} = '0;

        // multiply, MULT_LAT=4
        ex_mult = 1'b1;
        step("mul0", MS, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0);
        ex_mult = 1'b0;
        step("mul1", MS, 3'b000, 2'b00, 2'b00, 2'b01, 2, 0);
        step("mul2", MS, 3'b000, 2'b00, 2'b00, 2'b01, 3, 0);
        step("mul3", MS, 3'b000, 2'b00, 2'b00, 2'b01, 4, 0);
        step("mul_done", EN, 3'b000, 2'b00, 2'b00, 2'b00, 5, 0);

        // branch taken during the multiply
        ex_mult = 1'b1;
        step("bmul0", MS, 3'b000, 2'b00, 2'b00, 2'b00, 5, 0);
        ex_mult = 1'b0;
        step("bmul1", MS, 3'b000, 2'b00, 2'b00, 2'b01, 6, 0);
        mem_br_taken = 1'b1;
        step("bmul_br", EN, 3'b111, 2'b00, 2'b00, 2'b01, 7, 0);
        mem_br_taken = 1'b0;
        step("bmul_after", EN, 3'b000, 2'b00, 2'b00, 2'b00, 7, 1);

        // forwarding: EX/MEM wins, then MEM/WB, then regfile
        mem_regwrite = 1'b1; wb_regwrite = 1'b1; mem_rw = 5'd5; wb_rw = 5'd5;
        ex_rn = 5'd5; ex_rm = 5'd5;
        step("fwd_mem", EN, 3'b000, 2'b10, 2'b10, 2'b00, 7, 1);
        mem_regwrite = 1'b0;
        step("fwd_wb", EN, 3'b000, 2'b01, 2'b01, 2'b00, 7, 1);
        ex_rm = 5'd6; mem_regwrite = 1'b1; mem_rw = 5'd6;
        step("fwd_mix", EN, 3'b000, 2'b01, 2'b10, 2'b00, 7, 1);
        {mem_regwrite, wb_regwrite} = '0;

        // load-use on rm; unused source never stalls
        ex_memread = 1'b1; ex_rw = 5'd4; id_rn = 5'd4; id_rm = 5'd4; id_use_rm = 1'b1;
        step("lu_rm", LU, 3'b000, 2'b00, 2'b00, 2'b00, 7, 1);
        id_use_rm = 1'b0;
        step("lu_unused", EN, 3'b000, 2'b00, 2'b00, 2'b00, 8, 1);

        // branch beats load-use and a new multiply
        id_use_rn = 1'b1; mem_br_taken = 1'b1;
        step("br_lu", EN, 3'b111, 2'b00, 2'b00, 2'b00, 8, 1);
        {ex_memread, id_use_rn} = '0; ex_mult = 1'b1;
        step("br_mul", EN, 3'b111, 2'b00, 2'b00, 2'b00, 8, 2);
        step("br_3", EN, 3'b111, 2'b00, 2'b00, 2'b00, 8, 3);
        step("br_4", EN, 3'b111, 2'b00, 2'b00, 2'b00, 8, 4);
        mem_br_taken = 1'b0; ex_mult = 1'b0;
        step("br_after", EN, 3'b000, 2'b00, 2'b00, 2'b00, 8, 5);

        // saturation on the 2-bit copy
        total++;
        assert (s_sc === 2'b11) else begin
            bad++;
            $error("FAIL sat_stall observed=%h expected=%h", s_sc, 2'b11);
        end
        total++;
        assert (s_fc === 2'b11) else begin
            bad++;
            $error("FAIL sat_flush observed=%h expected=%h", s_fc, 2'b11);
        end

        // reset in the middle of a multiply
        ex_mult = 1'b1;
        step("rmul0", MS, 3'b000, 2'b00, 2'b00, 2'b00, 8, 5);
        ex_mult = 1'b0;
        step("rmul1", MS, 3'b000, 2'b00, 2'b00, 2'b01, 9, 5);
        reset = 1'b0;
        step("rmul_rst", 5'b00000, 3'b000, 2'b00, 2'b00, 2'b01, 10, 5);
        reset = 1'b1;
        step("rmul_rel", EN, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
